svn_seg_mon: RTL
================

Name: svn_seg_mon

Overview:
- Monitor/decoder for the board-check 7-segment bus, i.e. the receiving end of the segment driver.
- Samples `display_i`/`seg_sel_i` (looped back or probed) and synchronises them.
- Debounces the pattern, then decodes it back to a hex nibble.
- Checks that successive digits increment by 1 mod 16; reports lock, invalid patterns and sequence errors to board-check status logic.

Parameters:
- LED_POLARITY, 1'b0, 0 = segment inputs active-low (inverted before decode); 1 = active-high.
- DIGIT_SEL, 3'b010, `seg_sel_i` value identifying the monitored digit.
- STABLE_CYCLES, 4, consecutive identical samples required to accept a pattern; legal range 2..255.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  synchronous, active-high reset.
- display_i  input  8  segment bus; bit7 = dp, bits[6:0] = g..a.
- seg_sel_i  input  3  digit select.
- digit_o  output  4  last accepted decoded digit.
- dp_o  output  1  dp state of last accepted pattern (normalised, 1 = lit).
- digit_valid_o  output  1  1-cycle pulse, new valid digit accepted.
- invalid_o  output  1  1-cycle pulse, accepted pattern not in decode table.
- seq_err_o  output  1  1-cycle pulse, out-of-sequence digit while locked.
- locked_o  output  1  level, sequence tracking locked.
- err_cnt_o  output  ERR_CNT_W  saturating count of invalid + sequence errors.

Behaviour:
- Reset values: all outputs 0; internal state SEARCH; sync flops, held pattern and stability count 0. Reset mid-operation clears everything at that edge.
- Input path:
  - Two-flop synchroniser on `display_i` and `seg_sel_i`.
  - Normalise: seg = LED_POLARITY ? s2 : ~s2.
- Stability:
  - If synced select != DIGIT_SEL, count = 0.
  - Else if seg != held, then held = seg and count = 1.
  - Else count increments, saturating at STABLE_CYCLES.
- Accept: occurs on the cycle count becomes STABLE_CYCLES, and only if held differs from the last accepted pattern. An unchanged display is never re-accepted.
- Latency: new value present at `display_i` before edge 1 → event outputs registered at edge STABLE_CYCLES+3.
- Decode seg[6:0]:
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
  - Any other value is invalid.
- On accept, valid pattern: `digit_o` and `dp_o` update, `digit_valid_o` pulses, then the FSM step below.
- On accept, invalid pattern: `invalid_o` pulses, err_cnt +1, `digit_o` holds, state → SEARCH, `locked_o` = 0.
- FSM (evaluated on valid accepts only; ref = last accepted valid digit):
  - SEARCH: store ref → SYNC.
  - SYNC: if digit == ref+1 (4-bit wrap, F→0 legal), then `locked_o` = 1 and → LOCKED; else stay SYNC with ref = digit.
  - LOCKED: if digit == ref+1, stay. Else pulse `seq_err_o`, err_cnt +1, `locked_o` = 0, → SYNC with ref = digit.
- `err_cnt_o` saturates at all-ones. Simultaneous invalid and sequence error cannot occur, since an invalid pattern skips the FSM. Increment is at most 1 per cycle.

Optional Feature:
- Macro: SEG_MON_DP_CHECK_EN.
- Defined: dp must be lit for digit 0 and dark for 1..F. A mismatch on a decodable pattern is treated exactly as an invalid pattern (`invalid_o`, err_cnt +1, → SEARCH, `digit_o` holds, no `digit_valid_o`).
- Undefined: dp is ignored for validity and only reported on `dp_o`.

Test Plan:
- Reset, then drive `display_i` = ~8'hBF, `seg_sel_i` = 3'b010, held → after edge 7: `digit_o` = 0, `dp_o` = 1, `digit_valid_o` 1 cycle, `locked_o` = 0.
- Drive active-low patterns 0,1,2 each held 10 cycles → `locked_o` rises on the accept of 1; err_cnt = 0.
- Sequence E,F,0,1 → F→0 wrap accepted; `locked_o` stays 1; no `seq_err_o`.
- While locked at 3, present 5 → `seq_err_o` pulse, err_cnt = 1, `locked_o` = 0; then 6 → relock.
- Pattern ~8'h00 held (blank) → `invalid_o` pulse, err_cnt +1, `digit_o` unchanged. Toggle `seg_sel_i` to 3'b001 every 2 cycles → no accepts at all.
- Glitch: change `display_i` for 2 cycles with STABLE_CYCLES = 4 → no `digit_valid_o`. Assert `rst_i` mid-count → all outputs 0 next edge. Err count forced past 255 → holds 255.

Source files
------------

// File: rtl/svn_seg_mon.sv
// Receive-side monitor for the board-check 7-segment bus: sync, debounce, decode, sequence check.
// Optional build macro SEG_MON_DP_CHECK_EN: dp must be lit on digit 0 and dark on 1..F.
module svn_seg_mon #(
  parameter logic        LED_POLARITY  = 1'b0,
  parameter logic [2:0]  DIGIT_SEL     = 3'b010,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned ERR_CNT_W     = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [7:0]           display_i,
  input  logic [2:0]           seg_sel_i,
  output logic [3:0]           digit_o,
  output logic                 dp_o,
  output logic                 digit_valid_o,
  output logic                 invalid_o,
  output logic                 seq_err_o,
  output logic                 locked_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam logic [7:0] StableMax = 8'(STABLE_CYCLES);
  localparam logic [7:0] StablePre = 8'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {StSearch, StSync, StLocked} state_e;

  state_e     state_q;
  logic [7:0] disp_s1_q, disp_s2_q;
  logic [2:0] sel_s1_q, sel_s2_q;
  logic [7:0] held_q, last_q, cnt_q;
  logic       acc_q;
  logic [3:0] ref_q;

  logic [7:0] seg;
  logic       sel_hit;
  logic       dec_ok, pat_ok;
  logic [3:0] dec_digit, ref_inc;

  assign seg     = LED_POLARITY ? disp_s2_q : ~disp_s2_q;
  assign sel_hit = (sel_s2_q == DIGIT_SEL);
  assign ref_inc = ref_q + 4'd1;

  always_comb begin
    dec_ok    = 1'b1;
    dec_digit = 4'h0;
    case (held_q[6:0])
      7'h3F:   dec_digit = 4'h0;
      7'h06:   dec_digit = 4'h1;
      7'h5B:   dec_digit = 4'h2;
      7'h4F:   dec_digit = 4'h3;
      7'h66:   dec_digit = 4'h4;
      7'h6D:   dec_digit = 4'h5;
      7'h7D:   dec_digit = 4'h6;
      7'h07:   dec_digit = 4'h7;
      7'h7F:   dec_digit = 4'h8;
      7'h6F:   dec_digit = 4'h9;
      7'h77:   dec_digit = 4'hA;
      7'h7C:   dec_digit = 4'hB;
      7'h39:   dec_digit = 4'hC;
      7'h5E:   dec_digit = 4'hD;
      7'h79:   dec_digit = 4'hE;
      7'h71:   dec_digit = 4'hF;
      default: dec_ok    = 1'b0;
    endcase
  end

`ifdef SEG_MON_DP_CHECK_EN
  assign pat_ok = dec_ok && (held_q[7] == (dec_digit == 4'h0));
`else
  assign pat_ok = dec_ok;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      disp_s1_q     <= '0;
      disp_s2_q     <= '0;
      sel_s1_q      <= '0;
      sel_s2_q      <= '0;
      held_q        <= '0;
      last_q        <= '0;
      cnt_q         <= '0;
      acc_q         <= 1'b0;
      ref_q         <= '0;
      state_q       <= StSearch;
      digit_o       <= '0;
      dp_o          <= 1'b0;
      digit_valid_o <= 1'b0;
      invalid_o     <= 1'b0;
      seq_err_o     <= 1'b0;
      locked_o      <= 1'b0;
      err_cnt_o     <= '0;
    end else begin
      disp_s1_q <= display_i;
      disp_s2_q <= disp_s1_q;
      sel_s1_q  <= seg_sel_i;
      sel_s2_q  <= sel_s1_q;

      if (!sel_hit) begin
        cnt_q <= '0;
      end else if (seg != held_q) begin
        held_q <= seg;
        cnt_q  <= 8'd1;
      end else if (cnt_q != StableMax) begin
        cnt_q <= cnt_q + 8'd1;
      end
      // Flags the cycle the count reaches StableMax; acted on one edge later.
      acc_q <= sel_hit && (seg == held_q) && (cnt_q == StablePre);

      digit_valid_o <= 1'b0;
      invalid_o     <= 1'b0;
      seq_err_o     <= 1'b0;

      if (acc_q && (held_q != last_q)) begin
        last_q <= held_q;
        if (pat_ok) begin
          digit_o       <= dec_digit;
          dp_o          <= held_q[7];
          digit_valid_o <= 1'b1;
          ref_q         <= dec_digit;
          case (state_q)
            StSearch: state_q <= StSync;
            StSync: begin
              if (dec_digit == ref_inc) begin
                state_q  <= StLocked;
                locked_o <= 1'b1;
              end
            end
            StLocked: begin
              if (dec_digit != ref_inc) begin
                seq_err_o <= 1'b1;
                locked_o  <= 1'b0;
                state_q   <= StSync;
                if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
              end
            end
            default: state_q <= StSearch;
          endcase
        end else begin
          invalid_o <= 1'b1;
          locked_o  <= 1'b0;
          state_q   <= StSearch;
          if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
        end
      end
    end
  end

endmodule
